ps2_key_events: RTL and testbench

- Keyboard front end that sits directly upstream of the keyboard-to-ASCII stage.
- Receives raw PS/2 frames from the keyboard pins, validates framing, parity and timing, and folds the E0/F0 prefixes into single key events.
- Buffers the events in a small FIFO and presents them through the same available/read handshake the CPU keyboard register uses.

---
 rtl/bk_kbd_pkg.sv | 19 +
 rtl/ps2_frame_rx.sv | 124 ++++++++++++
 rtl/ps2_key_events.sv | 102 ++++++++++
 tb/tb_ps2_key_events.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bk_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
`timescale 1ns/1ps
package bk_kbd_pkg;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 receiver: pin synchronizers, clock glitch filter, 11-bit frame FSM
// and a partial-frame timeout. Emits one byte_valid_o or err_o pulse per frame.
`timescale 1ns/1ps
module ps2_frame_rx
    import bk_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

    logic [1:0]            clk_sync_q, data_sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  filt_q, fall_q;
    frame_state_t          state_q, state_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  valid_q, valid_d, err_q, err_d;
    logic                  data_s;

    assign data_s = data_sync_q[1];

    // Filtered clock only moves once the whole history agrees; the fall
    // strobe is raised in the same cycle the filtered level drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            hist_q      <= '1;
            filt_q      <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            hist_q      <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            if (&hist_q)
                filt_q <= 1'b1;
            else if (~|hist_q)
                filt_q <= 1'b0;
            fall_q      <= filt_q & ~|hist_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (fall_q) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d  = {data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7)
                        state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (data_s && (^shift_q ^ par_q))
                        valid_d = 1'b1;
                    else
                        err_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end else if (state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign err_o        = err_q;
endmodule

// File: rtl/ps2_key_events.sv
// Folds E0/F0 prefixes into key events and queues them in a small FIFO
// read through an available/read handshake.
`timescale 1ns/1ps
module ps2_key_events
    import bk_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_o,
    output logic       ext_o,
    output logic       release_o,
    output logic       available_o,
    input  logic       read_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    input  logic       clr_err_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    rx_byte;
    logic          rx_valid, rx_err;
    logic          ext_q, rel_q, ovf_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    key_event_t    mem [FIFO_DEPTH];
    key_event_t    head, new_ev;
    logic          is_ext, is_brk, push_req, full, do_pop, do_push;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i        (clk25),
        .rst_ni       (reset_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .err_o        (rx_err)
    );

    assign is_ext      = rx_valid && (rx_byte == PS2_PREFIX_EXT);
    assign is_brk      = rx_valid && (rx_byte == PS2_PREFIX_BRK);
    assign push_req    = rx_valid && !is_ext && !is_brk;
    assign full        = (count_q == FULL_CNT);
    assign available_o = (count_q != '0);
    assign do_pop      = read_i && available_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push     = push_req && (!full || do_pop);
    assign new_ev      = '{ext: ext_q, rel: rel_q, code: rx_byte};

    always_ff @(posedge clk25) begin
        if (do_push)
            mem[wr_ptr_q] <= new_ev;
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (is_ext)
                ext_q <= 1'b1;
            else if (is_brk)
                rel_q <= 1'b1;
            else if (push_req) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end
            if (push_req && full && !do_pop)
                ovf_q <= 1'b1;
            else if (clr_err_i)
                ovf_q <= 1'b0;
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)
                count_q <= count_q + 1'b1;
            else if (do_pop && !do_push)
                count_q <= count_q - 1'b1;
        end
    end

    assign head        = mem[rd_ptr_q];
    assign code_o      = available_o ? head.code : 8'h00;
    assign ext_o       = available_o ? head.ext  : 1'b0;
    assign release_o   = available_o ? head.rel  : 1'b0;
    assign frame_err_o = rx_err;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_ps2_key_events.sv
// Self-checking bench: frames are bit-banged onto the pins, expected events
// are queued as they are sent and compared as the FIFO is drained.
`timescale 1ns/1ps
module tb_ps2_key_events;
    localparam int TMO  = 3000;
    localparam int HALF = 30;

    logic       clk25 = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       read_i = 1'b0;
    logic       clr_err_i = 1'b0;
    logic [7:0] code_o;
    logic       ext_o, release_o, available_o, frame_err_o, overflow_o;

    int         total = 0;
    int         bad = 0;
    int         err_cnt = 0;
    int         e0;
    logic [9:0] sbq [$];
    logic       m_ext = 1'b0;
    logic       m_rel = 1'b0;
    logic       exp_ovf = 1'b0;

    ps2_key_events #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TMO),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk25       (clk25),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .code_o      (code_o),
        .ext_o       (ext_o),
        .release_o   (release_o),
        .available_o (available_o),
        .read_i      (read_i),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .clr_err_i   (clr_err_i)
    );

    always #20 clk25 = ~clk25;

    always @(negedge clk25) begin
        if (frame_err_o === 1'b1)
            err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic ps2_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk25);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk25);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        ps2_bits(bits, 11);
        repeat (HALF) @(posedge clk25);
    endtask

    task automatic send_key(input logic [7:0] b);
        if (b == 8'hE0)
            m_ext = 1'b1;
        else if (b == 8'hF0)
            m_rel = 1'b1;
        else begin
            if (sbq.size() < 4)
                sbq.push_back({m_ext, m_rel, b});
            else
                exp_ovf = 1'b1;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic read_check(input string tag);
        logic [9:0] exp;
        int n;
        n = 0;
        while (available_o !== 1'b1 && n < 2000) begin
            @(negedge clk25);
            n++;
        end
        if (available_o !== 1'b1) begin
            chk({tag, "_avail"}, 32'(available_o), 32'd1);
            return;
        end
        exp = (sbq.size() > 0) ? sbq.pop_front() : 10'h3FF;
        @(negedge clk25);
        chk({tag, "_ev"}, 32'({ext_o, release_o, code_o}), 32'(exp));
        @(posedge clk25);
        #1 read_i = 1'b1;
        @(posedge clk25);
        #1 read_i = 1'b0;
        @(negedge clk25);
        chk({tag, "_after"}, 32'(available_o), 32'(sbq.size() > 0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] codes [5];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

        repeat (3) @(negedge clk25);
        chk("rst_outs", 32'({code_o, ext_o, release_o, available_o, frame_err_o, overflow_o}), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(posedge clk25);

        // Plain make code, then a break and an extended break.
        send_key(8'h1C);
        read_check("t1");
        send_key(8'hF0);
        send_key(8'h1C);
        read_check("t2a");
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);
        read_check("t2b");

        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("t3_par_err", 32'(err_cnt - e0), 32'd1);
        chk("t3_par_avail", 32'(available_o), 32'd0);
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("t3_stop_err", 32'(err_cnt - e0), 32'd1);
        chk("t3_stop_avail", 32'(available_o), 32'd0);

        exp_ovf = 1'b0;
        for (int i = 0; i < 5; i++)
            send_key(codes[i]);
        repeat (5) @(negedge clk25);
        chk("t4_ovf", 32'(overflow_o), 32'(exp_ovf));
        for (int i = 0; i < 4; i++)
            read_check("t4");
        @(posedge clk25);
        #1 clr_err_i = 1'b1;
        @(posedge clk25);
        #1 clr_err_i = 1'b0;
        @(negedge clk25);
        chk("t4_clr", 32'(overflow_o), 32'd0);

        // Start bit plus four data bits, then the keyboard goes quiet.
        e0 = err_cnt;
        ps2_bits(11'h7F6, 5);
        repeat (TMO + 200) @(posedge clk25);
        chk("t5_tmo_err", 32'(err_cnt - e0), 32'd1);
        send_key(8'h29);
        read_check("t5");
        e0 = err_cnt;
        ps2_data = 1'b1;
        @(posedge clk25);
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge clk25);
        #1 ps2_clk = 1'b1;
        repeat (40) @(posedge clk25);
        chk("t5_glitch_err", 32'(err_cnt - e0), 32'd0);
        chk("t5_glitch_avail", 32'(available_o), 32'd0);

        send_key(8'h33);
        ps2_bits(11'h0B4, 6);
        reset_n = 1'b0;
        sbq.delete();
        m_ext = 1'b0;
        m_rel = 1'b0;
        repeat (3) @(negedge clk25);
        chk("t6_rst_outs", 32'({code_o, ext_o, release_o, available_o, frame_err_o, overflow_o}), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(posedge clk25);
        send_key(8'h5A);
        read_check("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
